// File: rtl/loop_seq_pkg.sv
// loop_seq_pkg: state encoding and down-counter sizing shared by loop_sequencer.
package loop_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ACLR  = 3'd1,
    S_GAP   = 3'd2,
    S_START = 3'd3,
    S_WAIT  = 3'd4,
    S_HALT  = 3'd5
  } state_t;

  // One spare bit above what the longest duration needs.
  function automatic int CNT_W(input int aclr_c, input int gap_c,
                               input int start_c, input int tmo_c);
    int m;
    m = aclr_c;
    if (gap_c > m) m = gap_c;
    if (start_c > m) m = start_c;
    if (tmo_c > m) m = tmo_c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/loop_sequencer.sv
// loop_sequencer: aclr / gap / start / wait-for-done loop controller for ma_control.
// Define LOOP_SEQ_TIMEOUT_EN to retry an iteration whose done never arrives.
module loop_sequencer
  import loop_seq_pkg::*;
#(
  parameter int ACLR_CYCLES    = 1,
  parameter int GAP_CYCLES     = 1,
  parameter int START_CYCLES   = 1,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int ITER_W         = 16
) (
  input  logic              s_clk,
  input  logic              reset_in_n,
  input  logic              run,
  input  logic [ITER_W-1:0] iter_limit,
  input  logic              done,
  output logic              aclr,
  output logic              start,
  output logic              busy,
  output logic              finished,
  output logic [ITER_W-1:0] iter_cnt,
  output logic              timeout_err
);

  localparam int CW = CNT_W(ACLR_CYCLES, GAP_CYCLES, START_CYCLES, TIMEOUT_CYCLES);

  state_t            state, state_nx;
  logic [CW-1:0]     cnt, cnt_nx;
  logic [ITER_W-1:0] limit_q;
  logic [ITER_W-1:0] cnt_inc;
  logic              launch;
  logic              iter_end;
  logic              aclr_nx, start_nx, busy_nx, finished_nx;
`ifdef LOOP_SEQ_TIMEOUT_EN
  logic              tmo;
`endif

  // Down-counter preload: cycles spent in a state minus one.
  function automatic logic [CW-1:0] dur_load(input state_t s);
    case (s)
      S_ACLR:  return CW'(ACLR_CYCLES - 1);
      S_GAP:   return (GAP_CYCLES > 0) ? CW'(GAP_CYCLES - 1) : '0;
      S_START: return CW'(START_CYCLES - 1);
      S_WAIT:  return CW'(TIMEOUT_CYCLES - 1);
      default: return '0;
    endcase
  endfunction

  assign cnt_inc = iter_cnt + ITER_W'(1);

  always_ff @(posedge s_clk or negedge reset_in_n) begin
    if (!reset_in_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    launch   = 1'b0;
    iter_end = 1'b0;
`ifdef LOOP_SEQ_TIMEOUT_EN
    tmo      = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (run) begin
          launch   = 1'b1;
          state_nx = S_ACLR;
        end
      end
      S_ACLR: begin
        if (cnt == '0) state_nx = (GAP_CYCLES == 0) ? S_START : S_GAP;
      end
      S_GAP: begin
        if (cnt == '0) state_nx = S_START;
      end
      S_START: begin
        if (done) iter_end = 1'b1;
        else if (cnt == '0) state_nx = S_WAIT;
      end
      S_WAIT: begin
        if (done) iter_end = 1'b1;
`ifdef LOOP_SEQ_TIMEOUT_EN
        else if (cnt == '0) begin
          tmo      = 1'b1;
          state_nx = S_ACLR;
        end
`endif
      end
      S_HALT: begin
        if (!run) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase

    // Reaching the programmed limit wins over a pending relaunch.
    if (iter_end) begin
      if ((limit_q != '0) && (cnt_inc == limit_q)) state_nx = S_HALT;
      else if (run) state_nx = S_ACLR;
      else state_nx = S_IDLE;
    end

    if (state_nx != state) cnt_nx = dur_load(state_nx);
    else if (cnt != '0) cnt_nx = cnt - CW'(1);
    else cnt_nx = cnt;
  end

  always_comb begin
    aclr_nx     = (state_nx == S_ACLR);
    start_nx    = (state_nx == S_START);
    busy_nx     = (state_nx != S_IDLE) && (state_nx != S_HALT);
    finished_nx = (state_nx == S_HALT);
  end

  always_ff @(posedge s_clk or negedge reset_in_n) begin
    if (!reset_in_n) begin
      aclr     <= 1'b0;
      start    <= 1'b0;
      busy     <= 1'b0;
      finished <= 1'b0;
    end else begin
      aclr     <= aclr_nx;
      start    <= start_nx;
      busy     <= busy_nx;
      finished <= finished_nx;
    end
  end

  always_ff @(posedge s_clk or negedge reset_in_n) begin
    if (!reset_in_n) begin
      cnt      <= '0;
      limit_q  <= '0;
      iter_cnt <= '0;
    end else begin
      cnt <= cnt_nx;
      if (launch) begin
        limit_q  <= iter_limit;
        iter_cnt <= '0;
      end else if (iter_end) begin
        iter_cnt <= cnt_inc;
      end
    end
  end

`ifdef LOOP_SEQ_TIMEOUT_EN
  always_ff @(posedge s_clk or negedge reset_in_n) begin
    if (!reset_in_n) begin
      timeout_err <= 1'b0;
    end else if (launch) begin
      timeout_err <= 1'b0;
    end else if (tmo) begin
      timeout_err <= 1'b1;
    end
  end
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_loop_sequencer.sv
// tb_loop_sequencer: scoreboard bench for loop_sequencer (ACLR=2, GAP=1, START=3, TIMEOUT=16, ITER_W=8).
module tb_loop_sequencer;

  logic       s_clk;
  logic       reset_in_n;
  logic       run;
  logic [7:0] iter_limit;
  logic       done;
  logic       aclr, start, busy, finished, timeout_err;
  logic [7:0] iter_cnt;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  loop_sequencer #(
    .ACLR_CYCLES(2), .GAP_CYCLES(1), .START_CYCLES(3), .TIMEOUT_CYCLES(16), .ITER_W(8)
  ) dut (
    .s_clk(s_clk), .reset_in_n(reset_in_n), .run(run), .iter_limit(iter_limit), .done(done),
    .aclr(aclr), .start(start), .busy(busy), .finished(finished),
    .iter_cnt(iter_cnt), .timeout_err(timeout_err)
  );

  initial s_clk = 1'b0;
  always #5 s_clk = ~s_clk;

  task automatic tick();
    @(posedge s_clk);
    #1;
  endtask

  // Returns once start has been seen high and then low (FSM now in WAIT).
  task automatic wait_start_fall(output bit ok);
    bit saw;
    ok  = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (start) saw = 1'b1;
      else if (saw) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic do_iteration(input int dly, input bit drop_run, output bit ok);
    wait_start_fall(ok);
    if (ok) begin
      repeat (dly) tick();
      done = 1'b1;
      if (drop_run) run = 1'b0;
      tick();
      done = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset_in_n = 1'b0;
    tick();
    tick();
    checks++;
    if ({aclr, start, busy, finished, timeout_err} !== 5'b0 || iter_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_state: got a/s/b/f/t=%b%b%b%b%b cnt=%0d expected 00000 cnt=0",
               aclr, start, busy, finished, timeout_err, iter_cnt);
    end
    reset_in_n = 1'b1;
    tick();
    checks++;
    if ({aclr, busy, finished} !== 3'b0) begin
      errors++;
      $display("FAIL reset_release_idle: got a/b/f=%b%b%b expected 000", aclr, busy, finished);
    end
  endtask

  task automatic test_single();
    logic exp_a, exp_s;
    logic [7:0] got;
    exp_q.delete();
    iter_limit = 8'd1;
    run = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      tick();
      exp_a = (k <= 2);
      exp_s = (k >= 4) && (k <= 6);
      checks++;
      if ({aclr, start, busy} !== {exp_a, exp_s, 1'b1}) begin
        errors++;
        $display("FAIL single_seq k=%0d: got aclr/start/busy=%b%b%b expected %b%b1",
                 k, aclr, start, busy, exp_a, exp_s);
      end
    end
    done = 1'b1;
    exp_q.push_back(8'd1);
    tick();
    done = 1'b0;
    got = exp_q.pop_front();
    checks++;
    if (iter_cnt !== got) begin
      errors++;
      $display("FAIL single_cnt: got %0d expected %0d", iter_cnt, got);
    end
    checks++;
    if ({finished, busy, aclr} !== 3'b100) begin
      errors++;
      $display("FAIL single_halt: got f/b/a=%b%b%b expected 100", finished, busy, aclr);
    end
    run = 1'b0;
    tick();
    checks++;
    if (finished !== 1'b0) begin
      errors++;
      $display("FAIL single_halt_exit: got finished=%b expected 0", finished);
    end
  endtask

  task automatic test_wrap();
    bit ok;
    logic [7:0] got;
    exp_q.delete();
    iter_limit = 8'd0;
    run = 1'b1;
    for (int i = 1; i <= 300; i++) begin
      exp_q.push_back(8'(i));
      do_iteration(0, (i == 300), ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL wrap_launch iter %0d: got no start pulse expected one", i);
        break;
      end
      got = exp_q.pop_front();
      checks++;
      if (iter_cnt !== got) begin
        errors++;
        $display("FAIL wrap_cnt iter %0d: got %0d expected %0d", i, iter_cnt, got);
      end
    end
    checks++;
    if (iter_cnt !== 8'd44 || busy !== 1'b0 || finished !== 1'b0) begin
      errors++;
      $display("FAIL wrap_final: got cnt=%0d busy=%b fin=%b expected 44 0 0", iter_cnt, busy, finished);
    end
    run = 1'b0;
    tick();
  endtask

  task automatic test_graceful_stop();
    bit ok;
    logic [7:0] got;
    exp_q.delete();
    iter_limit = 8'd5;
    run = 1'b1;
    exp_q.push_back(8'd1);
    do_iteration(0, 1'b0, ok);
    got = exp_q.pop_front();
    checks++;
    if (!ok || iter_cnt !== got) begin
      errors++;
      $display("FAIL stop_iter1: got ok=%0d cnt=%0d expected 1 %0d", ok, iter_cnt, got);
    end
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (start) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    run = 1'b0;
    exp_q.push_back(8'd2);
    if (ok) do_iteration(3, 1'b0, ok);
    got = exp_q.pop_front();
    checks++;
    if (!ok || iter_cnt !== got) begin
      errors++;
      $display("FAIL stop_iter2: got ok=%0d cnt=%0d expected 1 %0d", ok, iter_cnt, got);
    end
    checks++;
    if (busy !== 1'b0 || finished !== 1'b0) begin
      errors++;
      $display("FAIL stop_idle: got busy=%b fin=%b expected 0 0", busy, finished);
    end
    repeat (3) tick();
    checks++;
    if (aclr !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL stop_no_relaunch: got aclr=%b busy=%b expected 0 0", aclr, busy);
    end
  endtask

  task automatic test_done_filter();
    bit ok;
    logic [7:0] got;
    exp_q.delete();
    iter_limit = 8'd2;
    run = 1'b1;
    done = 1'b1;
    repeat (4) tick();
    checks++;
    if (iter_cnt !== 8'd0 || start !== 1'b1) begin
      errors++;
      $display("FAIL done_ignored: got cnt=%0d start=%b expected 0 1", iter_cnt, start);
    end
    exp_q.push_back(8'd1);
    tick();
    done = 1'b0;
    got = exp_q.pop_front();
    checks++;
    if (iter_cnt !== got || start !== 1'b0 || aclr !== 1'b1) begin
      errors++;
      $display("FAIL done_in_start: got cnt=%0d start=%b aclr=%b expected %0d 0 1",
               iter_cnt, start, aclr, got);
    end
    run = 1'b0;
    exp_q.push_back(8'd2);
    do_iteration(1, 1'b0, ok);
    got = exp_q.pop_front();
    checks++;
    if (!ok || iter_cnt !== got || finished !== 1'b1) begin
      errors++;
      $display("FAIL done_limit: got ok=%0d cnt=%0d fin=%b expected 1 %0d 1", ok, iter_cnt, finished, got);
    end
    tick();
    checks++;
    if (finished !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL done_halt_exit: got fin=%b busy=%b expected 0 0", finished, busy);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int n;
    logic [7:0] got;
    exp_q.delete();
    iter_limit = 8'd1;
    run = 1'b1;
    wait_start_fall(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL tmo_launch: got no start pulse expected one");
    end
`ifdef LOOP_SEQ_TIMEOUT_EN
    n = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      n++;
      if (aclr) break;
    end
    checks++;
    if (n !== 16 || aclr !== 1'b1 || timeout_err !== 1'b1 || iter_cnt !== 8'd0) begin
      errors++;
      $display("FAIL tmo_expire: got cycles=%0d aclr=%b err=%b cnt=%0d expected 16 1 1 0",
               n, aclr, timeout_err, iter_cnt);
    end
    exp_q.push_back(8'd1);
    do_iteration(0, 1'b0, ok);
    got = exp_q.pop_front();
    checks++;
    if (!ok || iter_cnt !== got || finished !== 1'b1 || timeout_err !== 1'b1) begin
      errors++;
      $display("FAIL tmo_retry: got ok=%0d cnt=%0d fin=%b err=%b expected 1 %0d 1 1",
               ok, iter_cnt, finished, timeout_err, got);
    end
`else
    n = 0;
    repeat (40) begin
      tick();
      n++;
    end
    checks++;
    if (busy !== 1'b1 || aclr !== 1'b0 || start !== 1'b0 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL tmo_hold after %0d: got b/a/s/e=%b%b%b%b expected 1000", n, busy, aclr, start, timeout_err);
    end
    done = 1'b1;
    exp_q.push_back(8'd1);
    tick();
    done = 1'b0;
    got = exp_q.pop_front();
    checks++;
    if (iter_cnt !== got || finished !== 1'b1) begin
      errors++;
      $display("FAIL tmo_late_done: got cnt=%0d fin=%b expected %0d 1", iter_cnt, finished, got);
    end
`endif
    run = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    bit ok;
    logic [7:0] got;
    exp_q.delete();
    iter_limit = 8'd3;
    run = 1'b1;
    exp_q.push_back(8'd1);
    do_iteration(0, 1'b0, ok);
    got = exp_q.pop_front();
    checks++;
    if (!ok || iter_cnt !== got) begin
      errors++;
      $display("FAIL rst_pre_iter: got ok=%0d cnt=%0d expected 1 %0d", ok, iter_cnt, got);
    end
    wait_start_fall(ok);
    tick();
    reset_in_n = 1'b0;
    #1;
    checks++;
    if (!ok || {aclr, start, busy, finished, timeout_err} !== 5'b0 || iter_cnt !== 8'd0) begin
      errors++;
      $display("FAIL rst_mid_wait: got a/s/b/f/t=%b%b%b%b%b cnt=%0d expected 00000 0",
               aclr, start, busy, finished, timeout_err, iter_cnt);
    end
    run = 1'b0;
    tick();
    reset_in_n = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || aclr !== 1'b0) begin
      errors++;
      $display("FAIL rst_idle: got busy=%b aclr=%b expected 0 0", busy, aclr);
    end
    run = 1'b1;
    tick();
    checks++;
    if (aclr !== 1'b1) begin
      errors++;
      $display("FAIL rst_relaunch_aclr: got aclr=%b expected 1", aclr);
    end
    #2;
    reset_in_n = 1'b0;
    #1;
    checks++;
    if ({aclr, start, busy, finished, timeout_err} !== 5'b0 || iter_cnt !== 8'd0) begin
      errors++;
      $display("FAIL rst_mid_aclr: got a/s/b/f/t=%b%b%b%b%b cnt=%0d expected 00000 0",
               aclr, start, busy, finished, timeout_err, iter_cnt);
    end
    tick();
    iter_limit = 8'd1;
    reset_in_n = 1'b1;
    exp_q.push_back(8'd1);
    do_iteration(0, 1'b0, ok);
    got = exp_q.pop_front();
    checks++;
    if (!ok || iter_cnt !== got || finished !== 1'b1) begin
      errors++;
      $display("FAIL rst_relaunch: got ok=%0d cnt=%0d fin=%b expected 1 %0d 1", ok, iter_cnt, finished, got);
    end
    run = 1'b0;
    tick();
  endtask

  initial begin
    reset_in_n = 1'b0;
    run        = 1'b0;
    done       = 1'b0;
    iter_limit = 8'd0;
    test_reset();
    test_single();
    test_wrap();
    test_graceful_stop();
    test_done_filter();
    test_timeout();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
